// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution sequencer.
package conv_pkg;
    localparam int CONV_DW   = 8;
    localparam int CONV_ACCW = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_EMIT,
        S_DONE
    } conv_state_t;

    // Index port width; a length-1 sequence still gets a 1-bit address.
    function automatic int idx_w(input int len);
        return (len <= 1) ? 1 : $clog2(len);
    endfunction
endpackage

// File: rtl/conv_index_gen.sv
// Range of valid k for output n, plus the h index n-k for the k being addressed.
module conv_index_gen import conv_pkg::*; #(
    parameter int N_X = 4,
    parameter int N_H = 4,
    parameter int XW  = idx_w(N_X),
    parameter int HW  = idx_w(N_H),
    parameter int YW  = idx_w(N_X + N_H - 1)
) (
    input  logic [YW-1:0] n,
    input  logic [XW-1:0] k,
    output logic [XW-1:0] k_lo,
    output logic [XW-1:0] k_hi,
    output logic [HW-1:0] h_idx
);
    localparam logic [YW-1:0] NH_M1 = YW'(N_H - 1);
    localparam logic [YW-1:0] NX_M1 = YW'(N_X - 1);

    logic [YW-1:0] lo_full;
    logic [YW-1:0] hi_full;
    logic [YW-1:0] h_full;

    // All arithmetic at output-index width; results always fit the narrower ports.
    always_comb begin
        lo_full = (n >= NH_M1) ? (n - NH_M1) : '0;
        hi_full = (n < NX_M1) ? n : NX_M1;
        h_full  = n - YW'(k);
        k_lo    = XW'(lo_full);
        k_hi    = XW'(hi_full);
        h_idx   = HW'(h_full);
    end
endmodule

// File: rtl/conv_sequencer.sv
// Linear convolution sequencer: walks each y[n]'s k range over one shared
// iterative multiplier, accumulates the products and emits y in index order.
module conv_sequencer import conv_pkg::*; #(
    parameter int  N_X  = 4,
    parameter int  N_H  = 4,
    parameter int  DW   = CONV_DW,
    parameter int  ACCW = CONV_ACCW,
    localparam int XW   = idx_w(N_X),
    localparam int HW   = idx_w(N_H),
    localparam int YW   = idx_w(N_X + N_H - 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [XW-1:0]   x_addr,
    output logic [HW-1:0]   h_addr,
    input  logic [DW-1:0]   x_data,
    input  logic [DW-1:0]   h_data,
    output logic            mul_start,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    input  logic            mul_done,
    input  logic [2*DW-1:0] mul_prod,
    output logic            y_valid,
    output logic [YW-1:0]   y_idx,
    output logic [ACCW-1:0] y_data,
    output logic            busy,
    output logic            done
);
    localparam logic [YW-1:0] N_LAST = YW'(N_X + N_H - 2);

    conv_state_t     state_q, state_d;
    logic [YW-1:0]   n_q, n_d;
    logic [XW-1:0]   k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic            mul_start_q, mul_start_d;
    logic [DW-1:0]   mul_a_q, mul_a_d;
    logic [DW-1:0]   mul_b_q, mul_b_d;
    logic            y_valid_q, y_valid_d;
    logic [YW-1:0]   y_idx_q, y_idx_d;
    logic [ACCW-1:0] y_data_q, y_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [XW-1:0]   k_lo, k_hi, k_addr;
    logic [ACCW-1:0] acc_sum;

    conv_index_gen #(
        .N_X (N_X),
        .N_H (N_H),
        .XW  (XW),
        .HW  (HW),
        .YW  (YW)
    ) u_index_gen (
        .n     (n_q),
        .k     (k_addr),
        .k_lo  (k_lo),
        .k_hi  (k_hi),
        .h_idx (h_addr)
    );

    // Address the term about to be issued one cycle early, so its operands are
    // latched together with mul_start and stay put for the whole multiply.
    always_comb begin
        k_addr = k_q;
        if (state_q == S_SETUP) begin
            k_addr = k_lo;
        end else if (state_q == S_ACC && k_q != k_hi) begin
            k_addr = k_q + XW'(1);
        end
    end

    assign x_addr  = k_addr;
    assign acc_sum = acc_q + ACCW'($signed(prod_q));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        y_valid_d   = 1'b0;
        y_idx_d     = y_idx_q;
        y_data_d    = y_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                k_d         = k_lo;
                acc_d       = '0;
                mul_a_d     = x_data;
                mul_b_d     = h_data;
                mul_start_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    prod_d  = mul_prod;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_sum;
                if (k_q == k_hi) begin
                    y_valid_d = 1'b1;
                    y_idx_d   = n_q;
                    y_data_d  = acc_sum;
                    state_d   = S_EMIT;
                end else begin
                    k_d         = k_addr;
                    mul_a_d     = x_data;
                    mul_b_d     = h_data;
                    mul_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_EMIT: begin
                if (n_q == N_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + YW'(1);
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            y_valid_q   <= 1'b0;
            y_idx_q     <= '0;
            y_data_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            y_valid_q   <= y_valid_d;
            y_idx_q     <= y_idx_d;
            y_data_q    <= y_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign y_valid   = y_valid_q;
    assign y_idx     = y_idx_q;
    assign y_data    = y_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
